// File: rtl/updown_counter_ctl.sv
// Up/down event counter with debounced clear/direction push-buttons, prescaled
// enable, programmable [0, LIMIT] range that wraps or saturates, and a parallel load.
module updown_counter_ctl #(
  parameter int WIDTH    = 32,
  parameter int PRESCALE = 1,
  parameter int DEBOUNCE = 16,
  parameter int SATURATE = 0,
  parameter int LED_W    = 8,
  parameter int LED_LSB  = 20
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             KEY_CLR_N,
  input  logic             KEY_UP,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic [WIDTH-1:0] LIMIT,
  output logic [WIDTH-1:0] COUNT,
  output logic [LED_W-1:0] LED,
  output logic             WRAP,
  output logic             AT_MAX,
  output logic             AT_ZERO
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE - 1);

  // key index 0 = clear (active low), 1 = direction (high = up)
  logic [1:0]         sync1, sync2, deb, deb_nxt;
  logic [1:0][DW-1:0] db_cnt, db_cnt_nxt;

  logic [PW-1:0]    pre, pre_nxt;
  logic [WIDTH-1:0] count_nxt, load_sat;
  logic             wrap_nxt, tick, clr_act, dir_up;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1  <= '1;
      sync2  <= '1;
      deb    <= '1;
      db_cnt <= '0;
    end else begin
      sync1  <= {KEY_UP, KEY_CLR_N};
      sync2  <= sync1;
      deb    <= deb_nxt;
      db_cnt <= db_cnt_nxt;
    end
  end

  always_comb begin
    deb_nxt    = deb;
    db_cnt_nxt = '0;
    for (int k = 0; k < 2; k++) begin
      if (sync2[k] != deb[k]) begin
        if (db_cnt[k] == DB_LAST) deb_nxt[k] = sync2[k];
        else                      db_cnt_nxt[k] = db_cnt[k] + 1'b1;
      end
    end
  end

  // Clear acts on the edge where the debounced level goes active, not one later.
  assign clr_act  = ~deb_nxt[0];
  assign dir_up   = deb[1];
  assign tick     = EN && (pre == PRE_LAST);
  assign load_sat = (LOAD_VAL > LIMIT) ? LIMIT : LOAD_VAL;

  always_comb begin
    count_nxt = COUNT;
    pre_nxt   = pre;
    wrap_nxt  = 1'b0;
    if (clr_act) begin
      count_nxt = '0;
      pre_nxt   = '0;
    end else if (LOAD) begin
      count_nxt = load_sat;
      pre_nxt   = '0;
    end else begin
      if (EN) pre_nxt = tick ? '0 : pre + 1'b1;
      if (tick) begin
        if (dir_up) begin
          if (COUNT < LIMIT) begin
            count_nxt = COUNT + 1'b1;
          end else if (SATURATE == 0) begin
            count_nxt = '0;
            wrap_nxt  = 1'b1;
          end else begin
            count_nxt = LIMIT;
          end
        end else begin
          if (COUNT > LIMIT) begin
            count_nxt = LIMIT;
          end else if (COUNT != '0) begin
            count_nxt = COUNT - 1'b1;
          end else if (SATURATE == 0) begin
            count_nxt = LIMIT;
            wrap_nxt  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      COUNT <= '0;
      pre   <= '0;
      WRAP  <= 1'b0;
    end else begin
      COUNT <= count_nxt;
      pre   <= pre_nxt;
      WRAP  <= wrap_nxt;
    end
  end

  assign LED     = COUNT[LED_LSB +: LED_W];
  assign AT_MAX  = (COUNT >= LIMIT);
  assign AT_ZERO = (COUNT == '0);

endmodule

// File: doc/updown_counter_ctl.md
Name: updown_counter_ctl

Overview:
Parametrised up/down event counter for the board top level. It has on-chip debounce of the two push-buttons (clear, direction) and a prescaled count enable. Count range is programmable, and it wraps or saturates at either end. A parallel load path is provided. A selectable bit window of the count drives the LED bank, and wrap pulses allow cascading into a second counter.

Parameters:
WIDTH, 32, count register width (2..32)
PRESCALE, 1, count once every PRESCALE enabled clocks (1..2^16)
DEBOUNCE, 16, consecutive synchronised cycles a key must hold a new level before it is accepted (>=1)
SATURATE, 0, 0 = wrap at range ends, 1 = hold at range ends
LED_W, 8, LED window width (<=WIDTH)
LED_LSB, 20, lowest count bit shown on LED (LED_LSB+LED_W<=WIDTH)

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous reset, active-high
KEY_CLR_N  in  1  raw button, low = clear count (asynchronous to CLK, bouncy)
KEY_UP  in  1  raw button, high = count up, low = count down (asynchronous, bouncy)
EN  in  1  count enable, synchronous
LOAD  in  1  synchronous load strobe
LOAD_VAL  in  WIDTH  value for LOAD
LIMIT  in  WIDTH  upper bound of range [0, LIMIT]; quasi-static
COUNT  out  WIDTH  current count (registered)
LED  out  LED_W  COUNT[LED_LSB+LED_W-1:LED_LSB]
WRAP  out  1  one-cycle pulse when count wraps (either direction)
AT_MAX  out  1  COUNT >= LIMIT (combinational decode of registered COUNT)
AT_ZERO  out  1  COUNT == 0 (combinational decode)

Behaviour:
- Reset (RST=1, async): COUNT=0, WRAP=0, prescaler=0, sync flops=1, debounce counters=0, debounced clr=inactive, debounced dir=up. LED=0, AT_ZERO=1, AT_MAX=(LIMIT==0).
- Key path, per key:
  - two-flop synchroniser;
  - debounce counter increments while the synced level differs from the debounced level, and clears to 0 when they match;
  - on reaching DEBOUNCE, the debounced level takes the synced level and the counter clears.
  - Latency from a clean input edge to the debounced change: 2+DEBOUNCE clocks.
  - Glitches shorter than DEBOUNCE cycles are ignored.
- Prescaler: counts 0..PRESCALE-1 only while EN=1; frozen while EN=0.
  - tick = EN && prescaler==PRESCALE-1; prescaler returns to 0 on tick.
  - PRESCALE=1 gives tick every EN cycle.
- Per-cycle priority, highest first:
  1. debounced clear active: COUNT<=0, prescaler<=0, WRAP<=0. Clear is level-held; COUNT stays 0 while the key is held.
  2. LOAD: COUNT<=min(LOAD_VAL,LIMIT), prescaler<=0, WRAP<=0.
  3. tick, direction up:
     - COUNT<LIMIT: COUNT+1.
     - COUNT>=LIMIT, SATURATE=0: COUNT<=0, WRAP<=1.
     - COUNT>=LIMIT, SATURATE=1: COUNT<=LIMIT, no WRAP.
  4. tick, direction down:
     - COUNT>LIMIT: COUNT<=LIMIT.
     - 0<COUNT<=LIMIT: COUNT-1.
     - COUNT==0, SATURATE=0: COUNT<=LIMIT, WRAP<=1.
     - COUNT==0, SATURATE=1: hold, no WRAP.
  5. otherwise: hold, WRAP<=0.
- COUNT updates on the tick edge, so tick-to-COUNT latency is 1 clock. WRAP is asserted in the same cycle COUNT shows the wrapped value, for exactly 1 clock.
- LIMIT=0: up or down tick with SATURATE=0 keeps COUNT=0 and pulses WRAP each tick.
- LIMIT=all-ones gives a full-range free-running counter; up-wrap 2^WIDTH-1 -> 0 with WRAP.
- LIMIT lowered below COUNT while running: the next tick is handled by the >= / > rules above. There is no out-of-range count.
- Direction change takes effect on the first tick after the debounced level changes. There is no lost or double count.
- RST mid-count: immediate return to reset values, with no dependence on the clock.

Test Plan:
Parameters for all scenarios: WIDTH=8, PRESCALE=1, DEBOUNCE=4, LED_LSB=0, LED_W=8, unless stated otherwise.
1. RST pulse mid-count at COUNT=0x37 -> COUNT=0, LED=0, AT_ZERO=1 with no clock edge. Release, EN=1, KEY_UP=1, LIMIT=0xFF -> COUNT 1,2,3 on successive clocks.
2. Wrap: LIMIT=9, SATURATE=0, up from 8 -> 9 (AT_MAX=1), then 0 with WRAP=1 for one cycle. Down from 0 -> 9 with WRAP=1. Repeat with SATURATE=1 -> holds 9 (up) and 0 (down), WRAP never asserted.
3. Debounce: KEY_CLR_N low for 3 cycles then high -> COUNT unaffected. Held low -> COUNT=0 exactly 6 clocks after the edge and stays 0 while held. KEY_UP bouncing 1-0-1-0 at 2-cycle spacing -> direction unchanged.
4. Priority: debounced clear, LOAD=1 (LOAD_VAL=0x20) and tick in the same cycle -> COUNT=0. LOAD with tick -> COUNT=0x20. LOAD_VAL=0x50 with LIMIT=0x40 -> COUNT=0x40.
5. Prescale: PRESCALE=5, EN=1 -> COUNT increments every 5th clock. EN dropped for 3 cycles mid-period -> next increment delayed by exactly 3 clocks.
6. LIMIT lowered from 0xFF to 0x10 with COUNT=0x30 -> next up tick gives 0 with WRAP=1. Next down tick from 0x30 (separate run) gives 0x10. Sanity check: LED tracks COUNT bits in every scenario.
